// File: rtl/pipe_ctrl_if.sv
// Control bundle between pipeline stages and the central controller.
// Pipeline-side modport is master; the controller is slave.
interface pipe_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  stallreq_if_i;
   logic                  stallreq_id_i;
   logic                  stallreq_exe_i;
   logic                  stallreq_mem_i;
   logic                  jump_req_i;
   logic [ADDR_WIDTH-1:0] jump_addr_i;
   logic                  int_req_i;
   logic [ADDR_WIDTH-1:0] int_vector_i;
   logic [ADDR_WIDTH-1:0] int_ret_addr_i;
   logic                  int_ret_valid_i;
   logic [5:0]            stall_o;
   logic                  flush_jump_o;
   logic                  flush_int_o;
   logic                  pc_redirect_o;
   logic [ADDR_WIDTH-1:0] pc_target_o;
   logic                  int_ack_o;
   logic [ADDR_WIDTH-1:0] epc_o;
   logic                  bus_timeout_o;

   modport master (
      output stallreq_if_i, stallreq_id_i, stallreq_exe_i,
      output stallreq_mem_i, jump_req_i, jump_addr_i,
      output int_req_i, int_vector_i, int_ret_addr_i,
      output int_ret_valid_i,
      input  stall_o, flush_jump_o, flush_int_o, pc_redirect_o,
      input  pc_target_o, int_ack_o, epc_o, bus_timeout_o
   );

   modport slave (
      input  stallreq_if_i, stallreq_id_i, stallreq_exe_i,
      input  stallreq_mem_i, jump_req_i, jump_addr_i,
      input  int_req_i, int_vector_i, int_ret_addr_i,
      input  int_ret_valid_i,
      output stall_o, flush_jump_o, flush_int_o, pc_redirect_o,
      output pc_target_o, int_ack_o, epc_o, bus_timeout_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall merge, jump/interrupt flush,
// interrupt entry sequencing and memory bus timeout detection.
module pipe_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255,
   parameter int CNT_WIDTH  = 8
) (
   input logic       clk_i,
   input logic       rst_n_i,
   pipe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_PRE = CNT_WIDTH'(TIMEOUT - 1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] vec_q;
   logic [ADDR_WIDTH-1:0] epc_q;
   logic [CNT_WIDTH-1:0]  cnt;
   logic                  timeout_q;
   logic [5:0]            stall_raw;
   logic [5:0]            stall;
   logic                  jump_take;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] target;

   always_comb begin
      stall_raw = 6'b000000;
      if (bus.stallreq_mem_i)
         stall_raw = 6'b011111;
      else if (bus.stallreq_exe_i)
         stall_raw = 6'b001111;
      else if (bus.stallreq_id_i)
         stall_raw = 6'b000111;
      else if (bus.stallreq_if_i)
         stall_raw = 6'b000011;
   end

   // FLUSH owns the pipeline: stalls and jumps are masked that cycle
   always_comb begin
      stall     = (state == FLUSH) ? 6'b000000 : stall_raw;
      jump_take = bus.jump_req_i & ~stall_raw[3] & (state != FLUSH);
      redirect  = (state == FLUSH) | jump_take;
      target    = '0;
      if (state == FLUSH)
         target = vec_q;
      else if (jump_take)
         target = bus.jump_addr_i;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.int_req_i)
               state_nxt = PEND;
         end
         PEND: begin
            if (!bus.int_req_i)
               state_nxt = IDLE;
            else if (stall == 6'b000000 && !jump_take &&
                     bus.int_ret_valid_i)
               state_nxt = FLUSH;
         end
         FLUSH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
         vec_q <= '0;
         epc_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && bus.int_req_i)
            vec_q <= bus.int_vector_i;
         if (state == PEND && state_nxt == FLUSH)
            epc_q <= bus.int_ret_addr_i;
      end
   end

   // Pulse only on the edge that lands on TIMEOUT; saturation holds it off
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (!bus.stallreq_mem_i)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
         timeout_q <= bus.stallreq_mem_i && (cnt == CNT_PRE);
      end
   end

   assign bus.stall_o       = stall;
   assign bus.flush_jump_o  = jump_take;
   assign bus.flush_int_o   = (state == FLUSH);
   assign bus.int_ack_o     = (state == FLUSH);
   assign bus.pc_redirect_o = redirect;
   assign bus.pc_target_o   = target;
   assign bus.epc_o         = epc_q;
   assign bus.bus_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl with TIMEOUT=4.
// Expected values are queued at drive time and popped at sample time.
module tb_pipe_ctrl;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   passes = 0;
   int   total = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   pipe_ctrl_if #(.ADDR_WIDTH(32)) bus ();

   pipe_ctrl #(
      .ADDR_WIDTH(32),
      .TIMEOUT   (4),
      .CNT_WIDTH (8)
   ) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus.slave)
   );

   task automatic push(input string t, input logic [31:0] v);
      exp_t e;
      e.tag = t;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         $error("FAIL scoreboard_empty got %h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) passes++;
         else $error("FAIL %s got %h want %h", e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.stallreq_if_i   = 1'b0;
      bus.stallreq_id_i   = 1'b0;
      bus.stallreq_exe_i  = 1'b0;
      bus.stallreq_mem_i  = 1'b0;
      bus.jump_req_i      = 1'b0;
      bus.jump_addr_i     = '0;
      bus.int_req_i       = 1'b0;
      bus.int_vector_i    = '0;
      bus.int_ret_addr_i  = '0;
      bus.int_ret_valid_i = 1'b0;

      // reset state
      #2;
      push("rst_stall", 32'h0);
      push("rst_flush_int", 32'h0);
      push("rst_epc", 32'h0);
      push("rst_timeout", 32'h0);
      push("rst_redirect", 32'h0);
      pop_chk(32'(bus.stall_o));
      pop_chk(32'(bus.flush_int_o));
      pop_chk(bus.epc_o);
      pop_chk(32'(bus.bus_timeout_o));
      pop_chk(32'(bus.pc_redirect_o));
      #5 rst_n = 1'b1;

      // stall encoding
      tick();
      bus.stallreq_id_i = 1'b1;
      push("stall_id", 32'h07);
      settle();
      pop_chk(32'(bus.stall_o));
      tick();
      bus.stallreq_mem_i = 1'b1;
      push("stall_mem", 32'h1f);
      settle();
      pop_chk(32'(bus.stall_o));
      tick();
      bus.stallreq_mem_i = 1'b0;
      bus.stallreq_exe_i = 1'b1;
      bus.stallreq_id_i  = 1'b0;
      push("stall_exe", 32'h0f);
      settle();
      pop_chk(32'(bus.stall_o));
      tick();
      bus.stallreq_exe_i = 1'b0;
      bus.stallreq_if_i  = 1'b1;
      push("stall_if", 32'h03);
      settle();
      pop_chk(32'(bus.stall_o));
      tick();
      bus.stallreq_if_i = 1'b0;
      push("stall_none", 32'h00);
      settle();
      pop_chk(32'(bus.stall_o));

      // jump held off by EX stall, then taken
      tick();
      bus.jump_req_i     = 1'b1;
      bus.jump_addr_i    = 32'h100;
      bus.stallreq_exe_i = 1'b1;
      push("jump_held_flush", 32'h0);
      push("jump_held_redir", 32'h0);
      push("jump_held_target", 32'h0);
      settle();
      pop_chk(32'(bus.flush_jump_o));
      pop_chk(32'(bus.pc_redirect_o));
      pop_chk(bus.pc_target_o);
      tick();
      bus.stallreq_exe_i = 1'b0;
      push("jump_flush", 32'h1);
      push("jump_target", 32'h100);
      settle();
      pop_chk(32'(bus.flush_jump_o));
      pop_chk(bus.pc_target_o);
      tick();
      bus.stallreq_id_i = 1'b1;
      push("jump_id_stall_flush", 32'h1);
      settle();
      pop_chk(32'(bus.flush_jump_o));
      tick();
      bus.stallreq_id_i = 1'b0;
      bus.jump_req_i    = 1'b0;
      push("jump_off_target", 32'h0);
      settle();
      pop_chk(bus.pc_target_o);

      // clean interrupt: FLUSH two cycles after request
      tick();
      bus.int_req_i       = 1'b1;
      bus.int_vector_i    = 32'h80;
      bus.int_ret_valid_i = 1'b1;
      bus.int_ret_addr_i  = 32'h44;
      push("int_c0_ack", 32'h0);
      settle();
      pop_chk(32'(bus.int_ack_o));
      tick();
      push("int_c1_ack", 32'h0);
      settle();
      pop_chk(32'(bus.int_ack_o));
      tick();
      bus.jump_req_i  = 1'b1;
      bus.jump_addr_i = 32'h200;
      push("int_c2_flush", 32'h1);
      push("int_c2_ack", 32'h1);
      push("int_c2_target", 32'h80);
      push("int_c2_epc", 32'h44);
      push("int_c2_jump_masked", 32'h0);
      push("int_c2_redirect", 32'h1);
      settle();
      pop_chk(32'(bus.flush_int_o));
      pop_chk(32'(bus.int_ack_o));
      pop_chk(bus.pc_target_o);
      pop_chk(bus.epc_o);
      pop_chk(32'(bus.flush_jump_o));
      pop_chk(32'(bus.pc_redirect_o));
      bus.int_req_i = 1'b0;
      tick();
      push("int_c3_ack", 32'h0);
      push("int_c3_jump_target", 32'h200);
      settle();
      pop_chk(32'(bus.int_ack_o));
      pop_chk(bus.pc_target_o);
      bus.jump_req_i = 1'b0;

      // deferred: mem stall holds PEND for 5 cycles
      tick();
      bus.stallreq_mem_i = 1'b1;
      bus.int_req_i      = 1'b1;
      bus.int_vector_i   = 32'h90;
      bus.int_ret_addr_i = 32'h48;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         push($sformatf("defer_c%0d_ack", i), 32'h0);
         settle();
         pop_chk(32'(bus.int_ack_o));
      end
      tick();
      bus.stallreq_mem_i = 1'b0;
      push("defer_c5_ack", 32'h0);
      settle();
      pop_chk(32'(bus.int_ack_o));
      tick();
      push("defer_c6_ack", 32'h1);
      push("defer_c6_target", 32'h90);
      push("defer_c6_epc", 32'h48);
      settle();
      pop_chk(32'(bus.int_ack_o));
      pop_chk(bus.pc_target_o);
      pop_chk(bus.epc_o);
      bus.int_req_i = 1'b0;
      tick();
      push("defer_c7_ack", 32'h0);
      settle();
      pop_chk(32'(bus.int_ack_o));

      // withdrawn request during PEND
      tick();
      bus.int_req_i    = 1'b1;
      bus.int_vector_i = 32'hb0;
      tick();
      bus.int_req_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         push($sformatf("withdraw_c%0d_ack", i), 32'h0);
         settle();
         pop_chk(32'(bus.int_ack_o));
      end

      // timeout: one pulse, 4 cycles after assertion
      tick();
      bus.stallreq_mem_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         push($sformatf("to1_c%0d", i), (i == 4) ? 32'h1 : 32'h0);
         settle();
         pop_chk(32'(bus.bus_timeout_o));
      end
      tick();
      bus.stallreq_mem_i = 1'b0;
      push("to_release", 32'h0);
      settle();
      pop_chk(32'(bus.bus_timeout_o));
      tick();
      bus.stallreq_mem_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         if (i == 4) bus.stallreq_mem_i = 1'b0;
         push($sformatf("to2_c%0d", i), (i == 4) ? 32'h1 : 32'h0);
         settle();
         pop_chk(32'(bus.bus_timeout_o));
      end

      // async reset in the middle of FLUSH
      tick();
      bus.int_req_i      = 1'b1;
      bus.int_vector_i   = 32'ha0;
      bus.int_ret_addr_i = 32'h50;
      tick();
      tick();
      push("arst_pre_flush", 32'h1);
      settle();
      pop_chk(32'(bus.flush_int_o));
      rst_n = 1'b0;
      #2;
      push("arst_flush", 32'h0);
      push("arst_epc", 32'h0);
      push("arst_ack", 32'h0);
      pop_chk(32'(bus.flush_int_o));
      pop_chk(bus.epc_o);
      pop_chk(32'(bus.int_ack_o));
      bus.int_req_i = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         push($sformatf("arst_post_c%0d_ack", i), 32'h0);
         push($sformatf("arst_post_c%0d_redir", i), 32'h0);
         settle();
         pop_chk(32'(bus.int_ack_o));
         pop_chk(32'(bus.pc_redirect_o));
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
